// File: rtl/mac_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mac_pipe
// Brief    : Fully pipelined signed multiply-accumulate, product = A*B + C.
//            Sign/magnitude split at the input, one shift-add stage per bit
//            of |A| (MSB first), sign restore and addend add at the output.
//            One result per clock, latency N+1 edges from the sampling edge.
// Revision : 1.0 - initial release
// ============================================================================
module mac_pipe #(
    parameter int N = 32,
    parameter int M = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               data_rdy,
    input  logic [N-1:0]       multiplicand,
    input  logic [M-1:0]       multiplier,
    input  logic [M-1:0]       addend,
    output logic               res_rdy,
    output logic [N+M-1:0]     product
);

    localparam int P = N + M;

    // Stage 0 holds index 0; bit stages 1..N hold indices 1..N.
    // r_a is shifted left each stage so its MSB is always the next bit to use.
    logic [N-1:0]   r_a   [0:N];
    logic [M-1:0]   r_b   [0:N];
    logic [M-1:0]   r_c   [0:N];
    logic           r_s   [0:N];
    logic           r_v   [0:N];
    logic [P-2:0]   r_acc [1:N];

    // Magnitudes of the operands; the most negative value maps onto its
    // unsigned magnitude 2^(W-1) without overflow since the result is unsigned.
    logic [N-1:0]   w_abs_a;
    logic [M-1:0]   w_abs_b;
    logic           w_sign;

    assign w_abs_a = multiplicand[N-1] ? (-multiplicand) : multiplicand;
    assign w_abs_b = multiplier[M-1]   ? (-multiplier)   : multiplier;
    assign w_sign  = multiplicand[N-1] ^ multiplier[M-1];

    // Next accumulator value per bit stage: acc_k = 2*acc_{k-1} + bit*|B|.
    logic [P-2:0]   w_acc_prev [1:N];
    logic [P-2:0]   w_acc_nxt  [1:N];

    for (genvar k = 1; k <= N; k++) begin : g_stage
        if (k == 1) begin : g_first
            assign w_acc_prev[k] = '0;
        end else begin : g_rest
            assign w_acc_prev[k] = r_acc[k-1];
        end
        // Top bit lost by the shift is always zero because |A|*|B| fits P-1 bits.
        assign w_acc_nxt[k] = (w_acc_prev[k] << 1)
                            + (r_a[k-1][N-1] ? {{(N-1){1'b0}}, r_b[k-1]} : '0);
    end

    // Output stage: restore the sign, then add the sign-extended addend.
    logic [P-1:0]   w_mag;
    logic [P-1:0]   w_signed;
    logic [P-1:0]   w_result;

    assign w_mag    = {1'b0, r_acc[N]};
    assign w_signed = r_s[N] ? (-w_mag) : w_mag;
    assign w_result = w_signed + {{N{r_c[N][M-1]}}, r_c[N]};

    // Whole pipeline: valid bits always advance, data only loads behind a valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= N; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_c[k] <= '0;
                r_s[k] <= 1'b0;
                r_v[k] <= 1'b0;
            end
            for (int k = 1; k <= N; k++) begin
                r_acc[k] <= '0;
            end
            res_rdy <= 1'b0;
            product <= '0;
        end else begin
            r_v[0] <= data_rdy;
            if (data_rdy) begin
                r_a[0] <= w_abs_a;
                r_b[0] <= w_abs_b;
                r_c[0] <= addend;
                r_s[0] <= w_sign;
            end
            for (int k = 1; k <= N; k++) begin
                r_v[k] <= r_v[k-1];
                if (r_v[k-1]) begin
                    r_acc[k] <= w_acc_nxt[k];
                    r_a[k]   <= r_a[k-1] << 1;
                    r_b[k]   <= r_b[k-1];
                    r_c[k]   <= r_c[k-1];
                    r_s[k]   <= r_s[k-1];
                end
            end
            res_rdy <= r_v[N];
            if (r_v[N]) begin
                product <= w_result;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_pipe
// Brief    : Scoreboard bench for mac_pipe. Stimulus pushes expected product
//            and due cycle; a negedge monitor pops and compares on res_rdy.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_pipe;

    localparam int N   = 32;
    localparam int M   = 4;
    localparam int P   = N + M;
    localparam int LAT = N + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           data_rdy = 1'b0;
    logic [N-1:0]   a = '0;
    logic [M-1:0]   b = '0;
    logic [M-1:0]   c = '0;
    logic           res_rdy;
    logic [P-1:0]   product;

    int             checks = 0;
    int             errors = 0;
    int             cyc = 0;

    logic [P-1:0]   exp_q [$];
    int             due_q [$];
    logic [P-1:0]   last_prod = '0;
    logic [P-1:0]   m_exp;
    int             m_due;

    mac_pipe #(.N(N), .M(M)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_rdy     (data_rdy),
        .multiplicand (a),
        .multiplier   (b),
        .addend       (c),
        .res_rdy      (res_rdy),
        .product      (product)
    );

    always #5 clk = ~clk;

    // Counts rising edges so the monitor can check exact latency.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [P-1:0] model(input logic [N-1:0] ai,
                                           input logic [M-1:0] bi,
                                           input logic [M-1:0] ci);
        longint r;
        r = longint'($signed(ai)) * longint'($signed(bi)) + longint'($signed(ci));
        return r[P-1:0];
    endfunction

    task automatic send(input logic [N-1:0] ai, input logic [M-1:0] bi,
                        input logic [M-1:0] ci, input logic [P-1:0] e);
        @(negedge clk);
        a = ai;
        b = bi;
        c = ci;
        data_rdy = 1'b1;
        exp_q.push_back(e);
        due_q.push_back(cyc + 1 + LAT);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            data_rdy = 1'b0;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results still outstanding, required 0", exp_q.size());
            exp_q.delete();
            due_q.delete();
        end
    endtask

    // Monitor: compare on every valid output, otherwise require product to hold.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                last_prod = '0;
            end else if (res_rdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_res_rdy: cycle %0d product %0h, required no pulse", cyc, product);
                end else begin
                    m_exp = exp_q.pop_front();
                    m_due = due_q.pop_front();
                    if (product !== m_exp) begin
                        errors++;
                        $display("FAIL product: got %0h required %0h (cycle %0d)", product, m_exp, cyc);
                    end
                    checks++;
                    if (cyc != m_due) begin
                        errors++;
                        $display("FAIL latency: result at cycle %0d required cycle %0d", cyc, m_due);
                    end
                end
                last_prod = product;
            end else begin
                checks++;
                if (product !== last_prod) begin
                    errors++;
                    $display("FAIL hold: product %0h changed without res_rdy, required %0h", product, last_prod);
                end
                if (due_q.size() > 0 && due_q[0] <= cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_res_rdy: no pulse at cycle %0d, required at %0d", cyc, due_q[0]);
                    void'(exp_q.pop_front());
                    void'(due_q.pop_front());
                end
            end
        end
    end

    // Directed stimulus followed by random, round-trip and reset scenarios.
    initial begin
        logic [N-1:0] ra;
        logic [M-1:0] rb;
        logic [M-1:0] rc;
        int           dv;
        int           dd;
        int           q;
        int           r;

        repeat (3) @(negedge clk);
        checks++;
        if (res_rdy !== 1'b0) begin
            errors++;
            $display("FAIL reset_res_rdy: got %0b required 0", res_rdy);
        end
        checks++;
        if (product !== '0) begin
            errors++;
            $display("FAIL reset_product: got %0h required 0", product);
        end
        rst = 1'b0;

        // Basic single pulse, then a long idle to check the hold.
        send(32'd5, 4'd5, 4'd4, 36'd29);
        idle(40);

        // Sign combinations on consecutive cycles.
        send(-32'sd5, 4'd5,   -4'sd4, -36'sd29);
        send(32'd5,   -4'sd5, 4'd4,   -36'sd21);
        send(-32'sd5, -4'sd5, -4'sd4, 36'd21);
        send(32'd0,   -4'sd8, -4'sd3, -36'sd3);
        idle(40);

        // Extremes: no wrap in the product width.
        send(32'h8000_0000, 4'h8, 4'h7, 36'h4_0000_0007);
        send(32'h8000_0000, 4'h7, 4'h8, 36'hC_7FFF_FFF8);
        send(32'h7FFF_FFFF, 4'h8, 4'h8, 36'hC_0000_0000);
        idle(40);

        // Random operands with random gaps in data_rdy.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            ra = $urandom;
            rb = 4'($urandom);
            rc = 4'($urandom);
            send(ra, rb, rc, model(ra, rb, rc));
        end
        idle(40);
        drain();

        // Divider round trip: quotient*divisor + remainder rebuilds the dividend.
        for (int i = 0; i < 50; i++) begin
            dv = int'($urandom);
            rb = 4'($urandom_range(1, 15));
            dd = int'($signed(rb));
            if (dv == 32'sh8000_0000 && dd == -1) dv = 12345;
            q = dv / dd;
            r = dv % dd;
            send(q, rb, r[M-1:0], P'(longint'(dv)));
        end
        idle(40);
        drain();

        // Reset with ten operations in flight.
        for (int i = 0; i < 10; i++) begin
            send(32'd100 + 32'(i), 4'd3, 4'd1, 36'd0);
        end
        @(negedge clk);
        data_rdy = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        due_q.delete();
        checks++;
        if (res_rdy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_res_rdy: got %0b required 0", res_rdy);
        end
        checks++;
        if (product !== '0) begin
            errors++;
            $display("FAIL midreset_product: got %0h required 0", product);
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
        send(32'd3, -4'sd2, 4'd1, -36'sd5);
        idle(60);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
